// File: rtl/mgt_01_mul_unit.sv
// Iterative radix-2 shift-add RV32M multiplier (MUL/MULH/MULHSU/MULHU), one operation in flight.
// Optional build macro MUL_ZERO_BYPASS_EN: a zero operand skips the MULTIPLY phase.

package mgt_01_mul_pkg;
    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        MUL_    = 2'd0,
        MULH_   = 2'd1,
        MULHSU_ = 2'd2,
        MULHU_  = 2'd3
    } mul_ops_e;

    typedef enum logic {
        FREE = 1'b0,
        BUSY = 1'b1
    } fu_state_e;
endpackage

module mgt_01_mul_unit
    import mgt_01_mul_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            clk_en_i,
    input  logic            valid_i,
    input  logic [XLEN-1:0] multiplicand_i,
    input  logic [XLEN-1:0] multiplier_i,
    input  mul_ops_e        operation_i,
    output logic [XLEN-1:0] result_o,
    output logic            valid_o,
    output fu_state_e       fu_state_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MULTIPLY = 2'd1,
        FINISH   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [4:0]        count_q;
    mul_ops_e          op_q;
    logic              neg_q;
    logic [XLEN-1:0]   mcand_q;
    logic [XLEN-1:0]   mplier_q;
    logic [2*XLEN-1:0] prod_q;

    logic              sign_a, sign_b;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic [XLEN-1:0]   addend;
    logic [XLEN:0]     sum;
    logic [2*XLEN-1:0] signed_prod;
    logic              zero_op;

    // Unsigned operands are treated as sign 0, so their magnitude is the raw value.
    always_comb begin
        sign_a      = (operation_i != MULHU_) && multiplicand_i[XLEN-1];
        sign_b      = ((operation_i == MUL_) || (operation_i == MULH_)) && multiplier_i[XLEN-1];
        abs_a       = sign_a ? -multiplicand_i : multiplicand_i;
        abs_b       = sign_b ? -multiplier_i : multiplier_i;
        zero_op     = (multiplicand_i == '0) || (multiplier_i == '0);
        addend      = mplier_q[0] ? mcand_q : '0;
        sum         = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, addend};
        signed_prod = neg_q ? -prod_q : prod_q;
    end

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
`ifdef MUL_ZERO_BYPASS_EN
                    state_d = zero_op ? FINISH : MULTIPLY;
`else
                    state_d = MULTIPLY;
`endif
                end
            end
            MULTIPLY: if (count_q == 5'd31) state_d = FINISH;
            FINISH:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else if (clk_en_i) begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            count_q  <= '0;
            op_q     <= MUL_;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            result_o <= '0;
            valid_o  <= 1'b0;
        end else if (clk_en_i) begin
            valid_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        op_q     <= operation_i;
                        neg_q    <= sign_a ^ sign_b;
                        mcand_q  <= abs_a;
                        mplier_q <= abs_b;
                        prod_q   <= '0;
                        count_q  <= '0;
                    end
                end
                MULTIPLY: begin
                    // Carry lands in the product MSB; the retired multiplier bit falls off the bottom.
                    prod_q   <= {sum, prod_q[XLEN-1:1]};
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q + 5'd1;
                end
                FINISH: begin
                    result_o <= (op_q == MUL_) ? signed_prod[XLEN-1:0]
                                               : signed_prod[2*XLEN-1:XLEN];
                    valid_o  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign fu_state_o = (state_q == IDLE) ? FREE : BUSY;

endmodule
